// File: rtl/reg_file_2w2r.sv
// Two-write / two-read register file with registered read ports, optional
// same-cycle write bypass, per-entry written flags and write-collision pulse.

module reg_file_2w2r_rdport #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_re,
    input  logic [ADDR_W-1:0]                    i_addr,
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]   i_mem,
    input  logic [(2**ADDR_W)-1:0]               i_wr,
    input  logic                                 i_we0,
    input  logic [ADDR_W-1:0]                    i_wa0,
    input  logic [DATA_W-1:0]                    i_wd0,
    input  logic                                 i_we1,
    input  logic [ADDR_W-1:0]                    i_wa1,
    input  logic [DATA_W-1:0]                    i_wd1,
    output logic [DATA_W-1:0]                    o_data,
    output logic                                 o_vld
);
    logic [DATA_W-1:0] w_data;
    logic              w_vld;
    logic [DATA_W-1:0] r_data;
    logic              r_vld;

    // Port 1 is applied last so it wins when both writes match the read address.
    always_comb begin
        w_data = i_mem[i_addr];
        w_vld  = i_wr[i_addr];
        if (BYPASS != 0) begin
            if (i_we0 && (i_wa0 == i_addr)) begin
                w_data = i_wd0;
                w_vld  = 1'b1;
            end
            if (i_we1 && (i_wa1 == i_addr)) begin
                w_data = i_wd1;
                w_vld  = 1'b1;
            end
        end
        if ((ZERO_REG != 0) && (i_addr == '0)) begin
            w_data = '0;
            w_vld  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_vld  <= 1'b0;
        end else if (i_re) begin
            r_data <= w_data;
            r_vld  <= w_vld;
        end
    end

    assign o_data = r_data;
    assign o_vld  = r_vld;
endmodule

module reg_file_2w2r #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              WE0,
    input  logic [ADDR_W-1:0] WR0_addr,
    input  logic [DATA_W-1:0] WR0_data,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] WR1_addr,
    input  logic [DATA_W-1:0] WR1_data,
    input  logic              RE,
    input  logic [ADDR_W-1:0] RA_addr,
    input  logic [ADDR_W-1:0] RB_addr,
    output logic [DATA_W-1:0] RA_data,
    output logic [DATA_W-1:0] RB_data,
    output logic              RA_vld,
    output logic              RB_vld,
    output logic              wr_conflict
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int NPORT = 2;

    logic [DEPTH-1:0][DATA_W-1:0] r_mem;
    logic [DEPTH-1:0]             r_wr;
    logic                         r_conflict;
    logic [DEPTH-1:0]             w_hit0;
    logic [DEPTH-1:0]             w_hit1;
    logic [NPORT-1:0][ADDR_W-1:0] w_raddr;
    logic [NPORT-1:0][DATA_W-1:0] w_rdata;
    logic [NPORT-1:0]             w_rvld;

    always_comb begin
        w_hit0 = '0;
        w_hit1 = '0;
        for (int e = 0; e < DEPTH; e++) begin
            w_hit0[e] = WE0 && (WR0_addr == ADDR_W'(e));
            w_hit1[e] = WE1 && (WR1_addr == ADDR_W'(e));
        end
    end

    // Entry 0 is never stored when hardwired; reads of it are forced in the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem <= '0;
            r_wr  <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (!((ZERO_REG != 0) && (e == 0))) begin
                    if (w_hit1[e]) begin
                        r_mem[e] <= WR1_data;
                        r_wr[e]  <= 1'b1;
                    end else if (w_hit0[e]) begin
                        r_mem[e] <= WR0_data;
                        r_wr[e]  <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_conflict <= 1'b0;
        else        r_conflict <= WE0 && WE1 && (WR0_addr == WR1_addr);
    end

    assign w_raddr = {RB_addr, RA_addr};

    for (genvar p = 0; p < NPORT; p++) begin : g_rd
        reg_file_2w2r_rdport #(
            .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
        ) u_rd (
            .clk(clk), .rst_n(rst_n), .i_re(RE), .i_addr(w_raddr[p]),
            .i_mem(r_mem), .i_wr(r_wr),
            .i_we0(WE0), .i_wa0(WR0_addr), .i_wd0(WR0_data),
            .i_we1(WE1), .i_wa1(WR1_addr), .i_wd1(WR1_data),
            .o_data(w_rdata[p]), .o_vld(w_rvld[p])
        );
    end

    assign RA_data     = w_rdata[0];
    assign RB_data     = w_rdata[1];
    assign RA_vld      = w_rvld[0];
    assign RB_vld      = w_rvld[1];
    assign wr_conflict = r_conflict;
endmodule

// File: tb/tb_reg_file_2w2r.sv
// Bench for reg_file_2w2r: two instances (bypass/no-zero and no-bypass/zero-reg)
// share stimulus and are checked against an array-based reference model.

module tb_reg_file_2w2r;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        WE0, WE1, RE;
    logic [2:0]  WR0_addr, WR1_addr, RA_addr, RB_addr;
    logic [15:0] WR0_data, WR1_data;
    logic [15:0] ra_d[2], rb_d[2];
    logic        ra_v[2], rb_v[2], cf[2];

    // config 0: ZERO_REG=0, BYPASS=1; config 1: ZERO_REG=1, BYPASS=0
    logic [15:0] m_mem[2][8];
    bit          m_wr[2][8];
    logic [15:0] m_ra[2], m_rb[2];
    bit          m_rav[2], m_rbv[2], m_cf[2];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reg_file_2w2r #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .WE0(WE0), .WR0_addr(WR0_addr), .WR0_data(WR0_data),
        .WE1(WE1), .WR1_addr(WR1_addr), .WR1_data(WR1_data),
        .RE(RE), .RA_addr(RA_addr), .RB_addr(RB_addr),
        .RA_data(ra_d[0]), .RB_data(rb_d[0]), .RA_vld(ra_v[0]), .RB_vld(rb_v[0]),
        .wr_conflict(cf[0])
    );

    reg_file_2w2r #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .WE0(WE0), .WR0_addr(WR0_addr), .WR0_data(WR0_data),
        .WE1(WE1), .WR1_addr(WR1_addr), .WR1_data(WR1_data),
        .RE(RE), .RA_addr(RA_addr), .RB_addr(RB_addr),
        .RA_data(ra_d[1]), .RB_data(rb_d[1]), .RA_vld(ra_v[1]), .RB_vld(rb_v[1]),
        .wr_conflict(cf[1])
    );

    function automatic void model_clear();
        for (int c = 0; c < 2; c++) begin
            for (int a = 0; a < 8; a++) begin
                m_mem[c][a] = '0;
                m_wr[c][a]  = 1'b0;
            end
            m_ra[c] = '0; m_rb[c] = '0;
            m_rav[c] = 1'b0; m_rbv[c] = 1'b0; m_cf[c] = 1'b0;
        end
    endfunction

    function automatic void mread(input int c, input logic [2:0] a,
                                  output logic [15:0] d, output bit v);
        if (c == 1 && a == 3'd0) begin
            d = '0; v = 1'b1;
        end else if (c == 0 && WE1 && WR1_addr == a) begin
            d = WR1_data; v = 1'b1;
        end else if (c == 0 && WE0 && WR0_addr == a) begin
            d = WR0_data; v = 1'b1;
        end else begin
            d = m_mem[c][a]; v = m_wr[c][a];
        end
    endfunction

    // Advance the model by one edge using the currently driven inputs, then clock.
    task automatic step();
        for (int c = 0; c < 2; c++) begin
            if (RE) begin
                mread(c, RA_addr, m_ra[c], m_rav[c]);
                mread(c, RB_addr, m_rb[c], m_rbv[c]);
            end
            m_cf[c] = WE0 && WE1 && (WR0_addr == WR1_addr);
            if (WE0 && !(c == 1 && WR0_addr == 3'd0)) begin
                m_mem[c][WR0_addr] = WR0_data; m_wr[c][WR0_addr] = 1'b1;
            end
            if (WE1 && !(c == 1 && WR1_addr == 3'd0)) begin
                m_mem[c][WR1_addr] = WR1_data; m_wr[c][WR1_addr] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        WE0 = 0; WE1 = 0; RE = 0;
        WR0_addr = 0; WR1_addr = 0; WR0_data = 0; WR1_data = 0;
        RA_addr = 0; RB_addr = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        model_clear();
        @(posedge clk); #1;
        for (int c = 0; c < 2; c++) begin
            n_chk++;
            if ({ra_d[c], rb_d[c], ra_v[c], rb_v[c], cf[c]} !== 35'd0) begin
                n_fail++;
                $display("FAIL reset_init dut%0d got %h %h %b %b %b want all 0",
                         c, ra_d[c], rb_d[c], ra_v[c], rb_v[c], cf[c]);
            end
        end
        rst_n = 1;
        // populate, then reset mid-cycle with a write and read in flight
        WE0 = 1; WR0_addr = 3; WR0_data = 16'h3333;
        WE1 = 1; WR1_addr = 5; WR1_data = 16'h5555;
        RE = 1; RA_addr = 3; RB_addr = 5;
        step();
        step();
        #2 rst_n = 0;
        #1;
        model_clear();
        for (int c = 0; c < 2; c++) begin
            n_chk++;
            if ({ra_d[c], rb_d[c], ra_v[c], rb_v[c], cf[c]} !== 35'd0) begin
                n_fail++;
                $display("FAIL reset_async dut%0d got %h %h %b %b %b want all 0",
                         c, ra_d[c], rb_d[c], ra_v[c], rb_v[c], cf[c]);
            end
        end
        @(posedge clk); #1;
        rst_n = 1;
        idle();
        RE = 1; RA_addr = 3; RB_addr = 5;
        step();
        for (int c = 0; c < 2; c++) begin
            n_chk++;
            if ({ra_d[c], rb_d[c], ra_v[c], rb_v[c]} !== 34'd0) begin
                n_fail++;
                $display("FAIL reset_read dut%0d got %h %h %b %b want 0 0 0 0",
                         c, ra_d[c], rb_d[c], ra_v[c], rb_v[c]);
            end
        end
    endtask

    task automatic test_dual_write();
        idle();
        WE0 = 1; WR0_addr = 1; WR0_data = 16'hABCD;
        WE1 = 1; WR1_addr = 2; WR1_data = 16'h0123;
        step();
        idle();
        RE = 1; RA_addr = 1; RB_addr = 2;
        step();
        for (int c = 0; c < 2; c++) begin
            n_chk++;
            if ({ra_d[c], rb_d[c], ra_v[c], rb_v[c], cf[c]} !== {16'hABCD, 16'h0123, 3'b110}) begin
                n_fail++;
                $display("FAIL dual_write dut%0d got %h %h %b %b cf=%b want abcd 0123 1 1 cf=0",
                         c, ra_d[c], rb_d[c], ra_v[c], rb_v[c], cf[c]);
            end
        end
    endtask

    task automatic test_collision();
        idle();
        WE0 = 1; WR0_addr = 4; WR0_data = 16'h1111;
        WE1 = 1; WR1_addr = 4; WR1_data = 16'h2222;
        step();
        for (int c = 0; c < 2; c++) begin
            n_chk++;
            if (cf[c] !== 1'b1) begin
                n_fail++;
                $display("FAIL collision_pulse dut%0d got cf=%b want 1", c, cf[c]);
            end
        end
        idle();
        RE = 1; RA_addr = 4; RB_addr = 4;
        step();
        for (int c = 0; c < 2; c++) begin
            n_chk++;
            if ({ra_d[c], rb_d[c], ra_v[c], rb_v[c], cf[c]} !== {16'h2222, 16'h2222, 3'b110}) begin
                n_fail++;
                $display("FAIL collision_data dut%0d got %h %h %b %b cf=%b want 2222 2222 1 1 cf=0",
                         c, ra_d[c], rb_d[c], ra_v[c], rb_v[c], cf[c]);
            end
        end
        // back-to-back collisions, the second at address 0
        idle();
        WE0 = 1; WE1 = 1; WR0_addr = 7; WR1_addr = 7; WR0_data = 16'h7; WR1_data = 16'h77;
        step();
        WR0_addr = 0; WR1_addr = 0;
        step();
        for (int c = 0; c < 2; c++) begin
            n_chk++;
            if (cf[c] !== 1'b1) begin
                n_fail++;
                $display("FAIL collision_b2b_zero dut%0d got cf=%b want 1", c, cf[c]);
            end
        end
        idle();
        step();
        for (int c = 0; c < 2; c++) begin
            n_chk++;
            if (cf[c] !== 1'b0) begin
                n_fail++;
                $display("FAIL collision_clear dut%0d got cf=%b want 0", c, cf[c]);
            end
        end
    endtask

    task automatic test_bypass();
        idle();
        WE0 = 1; WR0_addr = 6; WR0_data = 16'h5A5A;
        RE = 1; RA_addr = 6; RB_addr = 6;
        step();
        n_chk++;
        if ({ra_d[0], ra_v[0], rb_d[0], rb_v[0]} !== {16'h5A5A, 1'b1, 16'h5A5A, 1'b1}) begin
            n_fail++;
            $display("FAIL bypass_on got %h %b %h %b want 5a5a 1 5a5a 1",
                     ra_d[0], ra_v[0], rb_d[0], rb_v[0]);
        end
        n_chk++;
        if ({ra_d[1], ra_v[1], rb_d[1], rb_v[1]} !== 34'd0) begin
            n_fail++;
            $display("FAIL bypass_off got %h %b %h %b want 0 0 0 0",
                     ra_d[1], ra_v[1], rb_d[1], rb_v[1]);
        end
        // both ports hit the read address: port 1 wins on the bypass path
        WE1 = 1; WR1_addr = 6; WR1_data = 16'hC0DE; WR0_data = 16'hBEEF;
        step();
        n_chk++;
        if ({ra_d[0], ra_v[0]} !== {16'hC0DE, 1'b1}) begin
            n_fail++;
            $display("FAIL bypass_prio got %h %b want c0de 1", ra_d[0], ra_v[0]);
        end
        n_chk++;
        if ({ra_d[1], ra_v[1]} !== {16'h5A5A, 1'b1}) begin
            n_fail++;
            $display("FAIL nobypass_old got %h %b want 5a5a 1", ra_d[1], ra_v[1]);
        end
    endtask

    task automatic test_hold_zero();
        idle();
        RE = 1; RA_addr = 1; RB_addr = 2;
        step();
        RE = 0; RA_addr = 4; RB_addr = 6;
        WE0 = 1; WR0_addr = 1; WR0_data = 16'h9999;
        step();
        step();
        for (int c = 0; c < 2; c++) begin
            n_chk++;
            if ({ra_d[c], rb_d[c], ra_v[c], rb_v[c]} !== {16'hABCD, 16'h0123, 2'b11}) begin
                n_fail++;
                $display("FAIL hold dut%0d got %h %h %b %b want abcd 0123 1 1",
                         c, ra_d[c], rb_d[c], ra_v[c], rb_v[c]);
            end
        end
        idle();
        WE0 = 1; WR0_addr = 0; WR0_data = 16'hFFFF;
        step();
        idle();
        RE = 1; RA_addr = 0; RB_addr = 0;
        step();
        n_chk++;
        if ({ra_d[1], ra_v[1], rb_d[1], rb_v[1]} !== {16'h0000, 1'b1, 16'h0000, 1'b1}) begin
            n_fail++;
            $display("FAIL zero_reg got %h %b %h %b want 0 1 0 1",
                     ra_d[1], ra_v[1], rb_d[1], rb_v[1]);
        end
        n_chk++;
        if ({ra_d[0], ra_v[0]} !== {16'hFFFF, 1'b1}) begin
            n_fail++;
            $display("FAIL entry0_plain got %h %b want ffff 1", ra_d[0], ra_v[0]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            WE0 = ($urandom_range(0, 3) != 0);
            WE1 = ($urandom_range(0, 2) == 0);
            RE  = ($urandom_range(0, 3) != 0);
            WR0_addr = 3'($urandom_range(0, 7));
            WR1_addr = ($urandom_range(0, 3) == 0) ? WR0_addr : 3'($urandom_range(0, 7));
            WR0_data = 16'($urandom);
            WR1_data = 16'($urandom);
            RA_addr = ($urandom_range(0, 2) == 0) ? WR0_addr : 3'($urandom_range(0, 7));
            RB_addr = ($urandom_range(0, 2) == 0) ? WR1_addr : 3'($urandom_range(0, 7));
            step();
            for (int c = 0; c < 2; c++) begin
                n_chk++;
                if ({ra_d[c], rb_d[c], ra_v[c], rb_v[c], cf[c]} !==
                    {m_ra[c], m_rb[c], m_rav[c], m_rbv[c], m_cf[c]}) begin
                    n_fail++;
                    $display("FAIL random[%0d] dut%0d got %h %h %b %b %b want %h %h %b %b %b",
                             i, c, ra_d[c], rb_d[c], ra_v[c], rb_v[c], cf[c],
                             m_ra[c], m_rb[c], m_rav[c], m_rbv[c], m_cf[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_dual_write();
        test_collision();
        test_bypass();
        test_hold_zero();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
